ifmap_loader: RTL and testbench
===============================

# ifmap_loader

Byte-serial to vector packer and elastic buffer upstream of `ai_accelerator`. It accepts one INT8 activation byte per handshake from the host, assembles `ARRAY_SIZE` bytes into one ifmap vector, and queues vectors in a small FIFO. It drives the accelerator's `ifmap_data`/`ifmap_valid`/`ifmap_ready` handshake and stops after exactly `layer_size` vectors per layer.

## Interface
- `ARRAY_SIZE`, 4, lanes per vector; must match the systolic array.
- `DATA_WIDTH`, 8, bits per activation byte.
- `FIFO_DEPTH`, 8, vectors buffered; must be a power of two, at least 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse; begins a layer. Ignored unless the FSM is in IDLE.
- `layer_size`  in  8  vectors in this layer; sampled when `start` is accepted.
- `in_byte`  in  DATA_WIDTH  host activation byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts `in_byte` on this edge.
- `flush`  in  1  level; zero-pads and commits a partial vector.
- `ifmap_data`  out  ARRAY_SIZE*DATA_WIDTH  head vector; lane 0 is at `[DATA_WIDTH-1:0]`.
- `ifmap_valid`  out  1  head vector is valid.
- `ifmap_ready`  in  1  accelerator consumes the head vector.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  vectors currently queued.
- `busy`  out  1  FSM is in FILL or DRAIN.
- `done`  out  1  one-cycle pulse after the last vector is consumed.

## Operation
- FSM states: IDLE, FILL, DRAIN, DONE.
  - IDLE: on `start` with `layer_size`≠0, latch `layer_size` into `target` and go to FILL. On `start` with `layer_size`=0, go directly to DONE.
  - FILL: accept bytes. Go to DRAIN on the edge where `packed_cnt` reaches `target`.
  - DRAIN: no byte intake. Go to DONE on the edge where `sent_cnt` reaches `target`. FILL→DONE is also allowed if both counts reach `target` on the same edge.
  - DONE: lasts one cycle, then IDLE.
- Byte acceptance: `in_ready` = (state==FILL) && (`fifo_level` < FIFO_DEPTH). A byte is accepted when `in_valid` && `in_ready`.
- Packing:
  - An accepted byte is written to lane `lane_idx`, then `lane_idx` increments.
  - On accepting lane ARRAY_SIZE-1, the whole vector is pushed to the FIFO on that edge, `lane_idx` goes to 0, and `packed_cnt` increments.
- Flush:
  - Acts in FILL when `flush`=1, `lane_idx`≠0 and FIFO is not full. Lanes at or above `lane_idx` are zeroed, the vector is pushed, and `packed_cnt` increments.
  - If `flush` and an accepted byte coincide, the byte lands first. If that byte completes the vector, a normal push occurs with no extra vector.
  - `flush` with `lane_idx`=0 has no effect.
- Output side:
  - `ifmap_valid` = FIFO not empty && state∈{FILL, DRAIN}.
  - `ifmap_data` is the FIFO head (first-word fall-through), forced to 0 while `ifmap_valid`=0.
  - A pop happens when `ifmap_valid` && `ifmap_ready`, and increments `sent_cnt`.
- FIFO full/empty: a simultaneous push and pop leaves `fifo_level` unchanged. Pointers wrap modulo FIFO_DEPTH. Push at full cannot occur because `in_ready` is gated. Pop at empty cannot occur because `ifmap_valid` is gated.
- Counters: `packed_cnt` and `sent_cnt` are 8 bits and cleared on accepting `start`. `target`=255 is legal.
- Bytes offered in IDLE, DRAIN or DONE are not accepted (`in_ready`=0).

## Timing
- Reset values: `in_ready`=0, `ifmap_valid`=0, `ifmap_data`=0, `fifo_level`=0, `busy`=0, `done`=0. State is IDLE, and all counters, pointers and the packer are cleared.
- Reset asserted mid-layer: everything above is restored on the next edge. Queued vectors are discarded and no `done` is produced.
- `start` at edge N: `busy`=1 and `in_ready`=1 from cycle N+1.
- Packing latency: the byte completing a vector is accepted at edge N. With an empty FIFO, `ifmap_valid`=1 and data are visible in cycle N+1, so the accelerator can consume at edge N+1.
- Throughput: 1 byte/cycle in; 1 vector per ARRAY_SIZE cycles sustained out.
- `done`: the last pop occurs at edge M; `done`=1 in cycle M+1 and `busy`=0 in the same cycle. With `layer_size`=0, `done` is high in cycle N+1 after `start` at edge N.

## Structure
- Shared package `ai_accel_pkg`:
  - ARRAY_SIZE and DATA_WIDTH defaults.
  - Loader FSM state encoding: IDLE=2'd0, FILL=2'd1, DRAIN=2'd2, DONE=2'd3.
- Sub-module `vec_fifo`: synchronous first-word-fall-through FIFO with parameters WIDTH and DEPTH. It provides push, pop, head, level, full and empty, and is reusable for the ofmap path.
- The packer, counters and FSM live in `ifmap_loader`.

## Test plan
- Layer of 2 vectors: `layer_size`=2, bytes 01..08 streamed back to back with `ifmap_ready`=1 → vectors 0x04030201 then 0x08070605 are delivered, followed by a `done` pulse; total `sent_cnt`=2.
- Back-pressure: `ifmap_ready`=0, `layer_size`=20, continuous bytes → `fifo_level` saturates at 8 and `in_ready` drops after byte 32. Raising `ifmap_ready` then lets all 20 vectors arrive in order.
- Flush: `layer_size`=1, bytes AA,BB then `flush`=1 → one vector 0x0000BBAA is delivered, then `done`. Another `flush` with `lane_idx`=0 has no effect.
- Edge cases:
  - `layer_size`=0 → `done` in cycle N+1 after `start`, with no `in_ready`.
  - `start` while `busy` → ignored; `target` is unchanged.
- Reset mid-layer after 3 vectors are queued → next cycle `fifo_level`=0, `ifmap_valid`=0, `busy`=0, and no `done`. A fresh `layer_size`=1 layer then completes normally.

Source files
------------

// File: rtl/ai_accel_pkg.sv
// Shared constants and loader FSM encoding for the accelerator front end.
// Imported by the ifmap loader and reusable by the ofmap path.
package ai_accel_pkg;

    localparam int ARRAY_SIZE_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous first-word-fall-through FIFO; head_o shows the oldest entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module vec_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until level_q says so.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/ifmap_loader.sv
// Packs host activation bytes into ARRAY_SIZE-lane vectors, buffers them, and
// feeds exactly layer_size vectors per layer to the systolic array.
module ifmap_loader
    import ai_accel_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [7:0]                       layer_size,
    input  logic [DATA_WIDTH-1:0]            in_byte,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] ifmap_data,
    output logic                             ifmap_valid,
    input  logic                             ifmap_ready,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             busy,
    output logic                             done
);

    localparam int VEC_W  = ARRAY_SIZE * DATA_WIDTH;
    localparam int LANE_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    loader_state_e state_q, state_d;
    logic [7:0]    target_q, target_d;
    logic [7:0]    packed_cnt_q, packed_cnt_d;
    logic [7:0]    sent_cnt_q, sent_cnt_d;
    logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
    // The final lane is never stored: the completing byte goes straight into the push.
    logic [ARRAY_SIZE-2:0][DATA_WIDTH-1:0] lanes_q, lanes_d;

    logic [VEC_W-1:0] push_vec;
    logic [VEC_W-1:0] fifo_head;
    logic fifo_full, fifo_empty;
    logic accept, last_lane, flush_act, push, pop;

    assign in_ready    = (state_q == LD_FILL) && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign last_lane   = (lane_idx_q == LANE_W'(ARRAY_SIZE - 1));
    assign flush_act   = (state_q == LD_FILL) && flush && (lane_idx_q != '0)
                         && !fifo_full && !(accept && last_lane);
    assign push        = (accept && last_lane) || flush_act;
    assign ifmap_valid = !fifo_empty && ((state_q == LD_FILL) || (state_q == LD_DRAIN));
    assign pop         = ifmap_valid && ifmap_ready;
    assign ifmap_data  = ifmap_valid ? fifo_head : '0;
    assign busy        = (state_q == LD_FILL) || (state_q == LD_DRAIN);
    assign done        = (state_q == LD_DONE);

    // Lanes below lane_idx hold earlier bytes, the current byte lands on top, the rest are zero.
    always_comb begin
        push_vec = '0;
        for (int l = 0; l < ARRAY_SIZE - 1; l++) begin
            if (l < int'(lane_idx_q)) push_vec[l*DATA_WIDTH +: DATA_WIDTH] = lanes_q[l];
        end
        if (accept) push_vec[int'(lane_idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_byte;
    end

    always_comb begin
        lanes_d    = lanes_q;
        lane_idx_d = lane_idx_q;
        if (accept) begin
            if (!last_lane) lanes_d[lane_idx_q] = in_byte;
            lane_idx_d = lane_idx_q + LANE_W'(1);
        end
        if (push) lane_idx_d = '0;
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        packed_cnt_d = packed_cnt_q + 8'(push);
        sent_cnt_d   = sent_cnt_q + 8'(pop);
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    packed_cnt_d = '0;
                    sent_cnt_d   = '0;
                    if (layer_size == '0) begin
                        state_d = LD_DONE;
                    end else begin
                        target_d = layer_size;
                        state_d  = LD_FILL;
                    end
                end
            end
            LD_FILL: begin
                if (packed_cnt_d == target_q)
                    state_d = (sent_cnt_d == target_q) ? LD_DONE : LD_DRAIN;
            end
            LD_DRAIN: begin
                if (sent_cnt_d == target_q) state_d = LD_DONE;
            end
            LD_DONE:  state_d = LD_IDLE;
            default:  state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LD_IDLE;
            target_q     <= '0;
            packed_cnt_q <= '0;
            sent_cnt_q   <= '0;
            lane_idx_q   <= '0;
            lanes_q      <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            packed_cnt_q <= packed_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            lane_idx_q   <= lane_idx_d;
            lanes_q      <= lanes_d;
        end
    end

    vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_vec),
        .head_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ifmap_loader.sv
// Directed bench for ifmap_loader; a byte-level packing model feeds a queue of
// expected vectors that a negedge monitor compares against every consumed vector.
module tb_ifmap_loader;

    logic        clk;
    logic        rstN;
    logic        startIn;
    logic [7:0]  layerSize;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic        flushIn;
    logic [31:0] ifmapData;
    logic        ifmapValid;
    logic        ifmapReady;
    logic [3:0]  fifoLevel;
    logic        busyOut;
    logic        doneOut;

    int          checks;
    int          failures;
    int          rxCount;
    int          rxBase;
    int          tbIdx;
    logic [7:0]  tbLanes [4];
    logic [31:0] expQ [$];

    ifmap_loader dut (
        .clk         (clk),
        .rst_n       (rstN),
        .start       (startIn),
        .layer_size  (layerSize),
        .in_byte     (inByte),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .flush       (flushIn),
        .ifmap_data  (ifmapData),
        .ifmap_valid (ifmapValid),
        .ifmap_ready (ifmapReady),
        .fifo_level  (fifoLevel),
        .busy        (busyOut),
        .done        (doneOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every consumed vector must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstN && ifmapValid && ifmapReady) begin
            checkOutput("vectorExpected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) checkOutput("vectorData", ifmapData, expQ.pop_front());
            rxCount++;
        end
    end

    task automatic pushExpected();
        logic [31:0] vec;
        vec = '0;
        for (int l = 0; l < tbIdx; l++) vec[l*8 +: 8] = tbLanes[l];
        expQ.push_back(vec);
        tbIdx = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic f);
        logic r;
        bit   ok;
        int   prev;
        inByte  = b;
        inValid = 1'b1;
        flushIn = f;
        ok      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            r = inReady;
            nextCycle();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        flushIn = 1'b0;
        checkOutput("byteAccepted", 32'(ok), 32'd1);
        if (ok) begin
            prev          = tbIdx;
            tbLanes[tbIdx] = b;
            tbIdx++;
            if (tbIdx == 4 || (f && prev != 0)) pushExpected();
        end
    endtask

    task automatic flushOnly();
        flushIn = 1'b1;
        nextCycle();
        flushIn = 1'b0;
        if (tbIdx != 0) pushExpected();
    endtask

    task automatic startLayer(input logic [7:0] size);
        layerSize = size;
        startIn   = 1'b1;
        nextCycle();
        startIn   = 1'b0;
        tbIdx     = 0;
    endtask

    task automatic waitDone(input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (doneOut) begin
                seen = 1'b1;
                break;
            end
            nextCycle();
        end
        checkOutput("donePulse", 32'(seen), 32'd1);
        if (seen) begin
            checkOutput("busyAtDone", 32'(busyOut), 32'd0);
            checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
            nextCycle();
            checkOutput("doneOneCycle", 32'(doneOut), 32'd0);
        end
    endtask

    initial begin
        bit sawDone;
        checks = 0; failures = 0; rxCount = 0; tbIdx = 0;
        rstN = 1'b0; startIn = 1'b0; layerSize = '0; inByte = '0;
        inValid = 1'b0; flushIn = 1'b0; ifmapReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstInReady", 32'(inReady), 32'd0);
        checkOutput("rstValid", 32'(ifmapValid), 32'd0);
        checkOutput("rstData", ifmapData, 32'd0);
        checkOutput("rstLevel", 32'(fifoLevel), 32'd0);
        checkOutput("rstBusy", 32'(busyOut), 32'd0);
        checkOutput("rstDone", 32'(doneOut), 32'd0);
        rstN = 1'b1;
        nextCycle();

        $display("[TB] two-vector layer");
        ifmapReady = 1'b1;
        rxBase = rxCount;
        startLayer(8'd2);
        checkOutput("startBusy", 32'(busyOut), 32'd1);
        checkOutput("startInReady", 32'(inReady), 32'd1);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0);
        inValid = 1'b0;
        waitDone(30);
        checkOutput("twoVecCount", 32'(rxCount - rxBase), 32'd2);

        $display("[TB] back-pressure");
        ifmapReady = 1'b0;
        rxBase = rxCount;
        startLayer(8'd20);
        for (int i = 1; i <= 32; i++) applyStimulus(8'(i), 1'b0);
        checkOutput("bpLevelFull", 32'(fifoLevel), 32'd8);
        checkOutput("bpInReadyLow", 32'(inReady), 32'd0);
        inByte  = 8'd33;
        inValid = 1'b1;
        repeat (3) nextCycle();
        checkOutput("bpStillStalled", 32'(inReady), 32'd0);
        checkOutput("bpLevelHeld", 32'(fifoLevel), 32'd8);
        ifmapReady = 1'b1;
        for (int i = 33; i <= 80; i++) applyStimulus(8'(i), 1'b0);
        inValid = 1'b0;
        waitDone(60);
        checkOutput("bpVecCount", 32'(rxCount - rxBase), 32'd20);

        $display("[TB] flush partial vector");
        rxBase = rxCount;
        startLayer(8'd1);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        inValid = 1'b0;
        flushOnly();
        waitDone(20);
        checkOutput("flushVecCount", 32'(rxCount - rxBase), 32'd1);

        $display("[TB] flush with empty packer");
        ifmapReady = 1'b0;
        startLayer(8'd1);
        flushOnly();
        nextCycle();
        checkOutput("idleFlushLevel", 32'(fifoLevel), 32'd0);
        checkOutput("idleFlushValid", 32'(ifmapValid), 32'd0);
        ifmapReady = 1'b1;
        rxBase = rxCount;
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hC0 + i), 1'b0);
        inValid = 1'b0;
        waitDone(20);
        checkOutput("idleFlushVecCount", 32'(rxCount - rxBase), 32'd1);

        $display("[TB] flush coinciding with bytes");
        rxBase = rxCount;
        startLayer(8'd3);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h77, 1'b1);
        applyStimulus(8'h88, 1'b0);
        inValid = 1'b0;
        flushOnly();
        waitDone(20);
        checkOutput("coFlushVecCount", 32'(rxCount - rxBase), 32'd3);

        $display("[TB] zero-size layer");
        startLayer(8'd0);
        checkOutput("zeroDone", 32'(doneOut), 32'd1);
        checkOutput("zeroInReady", 32'(inReady), 32'd0);
        checkOutput("zeroBusy", 32'(busyOut), 32'd0);
        nextCycle();
        checkOutput("zeroDoneOnce", 32'(doneOut), 32'd0);

        $display("[TB] start while busy");
        rxBase = rxCount;
        startLayer(8'd1);
        startLayer(8'd5);
        checkOutput("busyStartIgnored", 32'(busyOut), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hE0 + i), 1'b0);
        inValid = 1'b0;
        waitDone(20);
        checkOutput("busyStartVecCount", 32'(rxCount - rxBase), 32'd1);

        $display("[TB] reset mid-layer");
        ifmapReady = 1'b0;
        startLayer(8'd5);
        for (int i = 0; i < 12; i++) applyStimulus(8'(8'h50 + i), 1'b0);
        inValid = 1'b0;
        checkOutput("midLevel", 32'(fifoLevel), 32'd3);
        checkOutput("midValid", 32'(ifmapValid), 32'd1);
        rstN = 1'b0;
        nextCycle();
        checkOutput("midRstLevel", 32'(fifoLevel), 32'd0);
        checkOutput("midRstValid", 32'(ifmapValid), 32'd0);
        checkOutput("midRstBusy", 32'(busyOut), 32'd0);
        checkOutput("midRstInReady", 32'(inReady), 32'd0);
        rstN = 1'b1;
        expQ.delete();
        tbIdx   = 0;
        sawDone = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (doneOut) sawDone = 1'b1;
            nextCycle();
        end
        checkOutput("midRstNoDone", 32'(sawDone), 32'd0);
        ifmapReady = 1'b1;
        rxBase = rxCount;
        startLayer(8'd1);
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hF0 + i), 1'b0);
        inValid = 1'b0;
        waitDone(20);
        checkOutput("postRstVecCount", 32'(rxCount - rxBase), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
